// File: rtl/qpsk_demodulator.sv
// QPSK hard-decision demodulator: four symbols are reassembled into one 7-bit word with confidence/pad flags.
// Latency: the word is registered on the edge that accepts its fourth symbol; out_valid is visible right after it.
// Backpressure: one-entry output buffer; in_ready drops only for the fourth symbol while a held word is not being taken.
module qpsk_demodulator #(
  parameter logic [15:0] CONF_THRESH = 16'd2896
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] symb_real,
  input  logic [15:0] symb_imag,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_word,
  output logic        out_low_conf,
  output logic        out_pad_err
);

  logic [1:0]  cnt;
  logic [6:1]  stage_word;
  logic        stage_low;
  logic        neg_r;
  logic        neg_i;
  logic [15:0] mag_r;
  logic [15:0] mag_i;
  logic        low_r;
  logic        low_i;
  logic        accept;
  logic        load;

  // Magnitude of a two's-complement sample; the most negative value saturates so it stays a positive 15-bit number.
  function automatic logic [15:0] sat_mag(input logic [15:0] x);
    logic [15:0] m;
    m = x;
    if (x[15]) begin
      if (x == 16'h8000) begin
        m = 16'h7FFF;
      end else begin
        m = ~x + 16'd1;
      end
    end
    return m;
  endfunction

  assign neg_r    = symb_real[15];
  assign neg_i    = symb_imag[15];
  assign mag_r    = sat_mag(symb_real);
  assign mag_i    = sat_mag(symb_imag);
  assign low_r    = (mag_r < CONF_THRESH);
  assign low_i    = (mag_i < CONF_THRESH);

  // The last symbol may only enter when the output buffer is free or draining this cycle.
  assign in_ready = (cnt != 2'd3) || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // Flush discards a coinciding symbol, so it also suppresses the word load.
  assign load     = accept && !flush && (cnt == 2'd3);

  // Symbol counter and staging of the first three decided symbols; flush restarts the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 2'd0;
      stage_word <= '0;
      stage_low  <= 1'b0;
    end else if (flush) begin
      cnt        <= 2'd0;
      stage_word <= '0;
      stage_low  <= 1'b0;
    end else if (accept) begin
      cnt <= cnt + 2'd1;
      case (cnt)
        2'd0: begin
          stage_word[6:5] <= {neg_i, neg_r};
          stage_low       <= low_r | low_i;
        end
        2'd1: begin
          stage_word[4:3] <= {neg_i, neg_r};
          stage_low       <= stage_low | low_r | low_i;
        end
        2'd2: begin
          stage_word[2:1] <= {neg_i, neg_r};
          stage_low       <= stage_low | low_r | low_i;
        end
        default: begin
          // Fourth symbol goes straight to the output buffer; staging is rewritten by the next word.
        end
      endcase
    end
  end

  // Output buffer: loads on the fourth symbol, drains on handshake, and a same-edge load keeps it full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_word     <= '0;
      out_low_conf <= 1'b0;
      out_pad_err  <= 1'b0;
    end else if (load) begin
      out_valid    <= 1'b1;
      out_word     <= {stage_word, neg_i};
      // Real part of the fourth symbol is padding: it feeds the pad check, never the confidence flag.
      out_low_conf <= stage_low | low_i;
      out_pad_err  <= neg_r;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qpsk_demodulator.sv
module tb_qpsk_demodulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] symb_real;
  logic [15:0] symb_imag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_word;
  logic        out_low_conf;
  logic        out_pad_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: symbols of the word in progress, expected and observed words as {word, low, pad}.
  logic [15:0] cur_r[$];
  logic [15:0] cur_i[$];
  logic [8:0]  exp_q[$];
  logic [8:0]  obs_q[$];

  qpsk_demodulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .symb_real   (symb_real),
    .symb_imag   (symb_imag),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_low_conf(out_low_conf),
    .out_pad_err (out_pad_err)
  );

  always #5 clk = ~clk;

  // Record every word handed downstream; values are stable at the falling edge before the transfer edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) obs_q.push_back({out_word, out_low_conf, out_pad_err});
  end

  function automatic bit is_neg(input logic [15:0] v);
    int s;
    s = $signed(v);
    return s < 0;
  endfunction

  function automatic bit is_low(input logic [15:0] v);
    int s;
    s = $signed(v);
    if (s < 0) s = -s;
    if (s > 32767) s = 32767;
    return s < 2896;
  endfunction

  // Model of one accepted symbol: after four of them the expected word is computed from the decision rules.
  task automatic model_accept(input logic [15:0] r, input logic [15:0] i);
    logic [6:0] w;
    bit low;
    cur_r.push_back(r);
    cur_i.push_back(i);
    if (cur_r.size() == 4) begin
      w   = '0;
      low = 0;
      for (int k = 0; k < 3; k++) begin
        w[6-2*k] = is_neg(cur_i[k]);
        w[5-2*k] = is_neg(cur_r[k]);
        low = low | is_low(cur_i[k]) | is_low(cur_r[k]);
      end
      w[0] = is_neg(cur_i[3]);
      low  = low | is_low(cur_i[3]);
      exp_q.push_back({w, low, is_neg(cur_r[3])});
      cur_r.delete();
      cur_i.delete();
    end
  endtask

  function automatic logic [15:0] amp(input logic b);
    return b ? 16'hE95F : 16'h16A1;
  endfunction

  // Offer one symbol and hold it until accepted; leaves in_valid high so calls chain back-to-back.
  task automatic drive_sym(input logic [15:0] r, input logic [15:0] i);
    int t;
    t = 0;
    in_valid  = 1'b1;
    symb_real = r;
    symb_imag = i;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      model_accept(r, i);
    end
  endtask

  task automatic send_word(input logic [6:0] w);
    drive_sym(amp(w[5]), amp(w[6]));
    drive_sym(amp(w[3]), amp(w[4]));
    drive_sym(amp(w[1]), amp(w[2]));
    drive_sym(16'h16A1, amp(w[0]));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    symb_real = '0; symb_imag = '0;
    #12;
    n_checks++;
    if ({out_valid, out_word, out_low_conf, out_pad_err} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b w=%h l=%b p=%b, required all 0", out_valid, out_word, out_low_conf, out_pad_err);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send_word(7'b1011001);
    n_checks++;
    if ({out_valid, out_word, out_low_conf, out_pad_err} !== {1'b1, 7'h59, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_latency: got v=%b w=%h l=%b p=%b, required v=1 w=59 l=0 p=0", out_valid, out_word, out_low_conf, out_pad_err);
    end
    idle(4);
    n_checks++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL basic_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
    end else begin
      n_checks++;
      if (obs_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL basic_word: got %h, required %h", obs_q[0], exp_q[0]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure;
    logic [6:0] w2;
    w2 = 7'h4C;
    idle(1);
    out_ready = 1'b0;
    send_word(7'h33);
    drive_sym(amp(w2[5]), amp(w2[6]));
    drive_sym(amp(w2[3]), amp(w2[4]));
    drive_sym(amp(w2[1]), amp(w2[2]));
    symb_real = 16'h16A1;
    symb_imag = amp(w2[0]);
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_word !== 7'h33) begin
        n_fail++;
        $display("FAIL bp_hold: got rdy=%b v=%b w=%h, required rdy=0 v=1 w=33", in_ready, out_valid, out_word);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive_sym(16'h16A1, amp(w2[0]));
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 7'h4C) begin
      n_fail++;
      $display("FAIL bp_same_edge: got v=%b w=%h, required v=1 w=4c", out_valid, out_word);
    end
    idle(4);
    n_checks++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL bp_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL bp_word%0d: got %h, required %h", k, obs_q[k], exp_q[k]);
        end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_confidence;
    out_ready = 1'b1;
    // word A: symbol 2 real small positive
    drive_sym(16'h16A1, 16'h16A1); drive_sym(16'h0100, 16'h16A1);
    drive_sym(16'h16A1, 16'h16A1); drive_sym(16'h16A1, 16'h16A1);
    // word B: symbol 2 real most negative
    drive_sym(16'h16A1, 16'h16A1); drive_sym(16'h8000, 16'h16A1);
    drive_sym(16'h16A1, 16'h16A1); drive_sym(16'h16A1, 16'h16A1);
    // word C: symbol 4 real zero
    drive_sym(16'h16A1, 16'h16A1); drive_sym(16'h16A1, 16'h16A1);
    drive_sym(16'h16A1, 16'h16A1); drive_sym(16'h0000, 16'h16A1);
    idle(4);
    n_checks++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 3) begin
      n_fail++;
      $display("FAIL conf_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL conf_word%0d: got %h, required %h", k, obs_q[k], exp_q[k]);
        end
      end
      n_checks++;
      if (obs_q[0][5] !== 1'b0 || obs_q[0][1] !== 1'b1) begin
        n_fail++;
        $display("FAIL conf_small: got bit3=%b low=%b, required bit3=0 low=1", obs_q[0][5], obs_q[0][1]);
      end
      n_checks++;
      if (obs_q[1][5] !== 1'b1 || obs_q[1][1] !== 1'b0) begin
        n_fail++;
        $display("FAIL conf_8000: got bit3=%b low=%b, required bit3=1 low=0", obs_q[1][5], obs_q[1][1]);
      end
      n_checks++;
      if (obs_q[2][1] !== 1'b0 || obs_q[2][0] !== 1'b0) begin
        n_fail++;
        $display("FAIL conf_pad_zero: got low=%b pad=%b, required 0 0", obs_q[2][1], obs_q[2][0]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_pad;
    out_ready = 1'b1;
    drive_sym(16'h16A1, 16'h16A1); drive_sym(16'h16A1, 16'h16A1);
    drive_sym(16'h16A1, 16'h16A1); drive_sym(16'hE95F, 16'h16A1);
    send_word(7'h01);
    idle(4);
    n_checks++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL pad_count: got %0d words, required 2", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0][0] !== 1'b1 || obs_q[0][2] !== 1'b0) begin
        n_fail++;
        $display("FAIL pad_err_set: got pad=%b bit0=%b, required pad=1 bit0=0", obs_q[0][0], obs_q[0][2]);
      end
      n_checks++;
      if (obs_q[1] !== {7'h01, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL pad_err_clear: got %h, required %h", obs_q[1], {7'h01, 1'b0, 1'b0});
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    drive_sym(amp(1'b0), amp(1'b1));
    drive_sym(amp(1'b0), amp(1'b1));
    // flush together with an offered symbol: the symbol is dropped
    flush     = 1'b1;
    in_valid  = 1'b1;
    symb_real = 16'hE95F;
    symb_imag = 16'hE95F;
    @(posedge clk);
    #1;
    cur_r.delete(); cur_i.delete();
    idle(1);
    send_word(7'h2A);
    idle(4);
    n_checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL flush_count: got %0d words, required 1", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0] !== {7'h2A, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL flush_word: got %h, required %h", obs_q[0], {7'h2A, 1'b0, 1'b0});
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    send_word(7'h15);
    drive_sym(amp(1'b1), amp(1'b0));
    drive_sym(amp(1'b0), amp(1'b1));
    drive_sym(amp(1'b1), amp(1'b0));
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_word, out_low_conf, out_pad_err} !== 10'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b w=%h l=%b p=%b rdy=%b, required 0s and rdy=1",
               out_valid, out_word, out_low_conf, out_pad_err, in_ready);
    end
    #1;
    rst_n = 1'b1;
    cur_r.delete(); cur_i.delete(); exp_q.delete(); obs_q.delete();
    idle(1);
    out_ready = 1'b1;
    send_word(7'h7F);
    idle(4);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL async_reset_count: got %0d words, required 1", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0][8:2] !== 7'h7F) begin
        n_fail++;
        $display("FAIL async_reset_word: got %h, required 7f", obs_q[0][8:2]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  function automatic logic [15:0] rnd_sample();
    logic [15:0] v;
    case ($urandom_range(0, 5))
      0:       v = 16'h8000;
      1:       v = 16'h0000;
      2:       v = 16'($urandom_range(0, 3000));
      3:       v = -16'($urandom_range(0, 3000));
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  task automatic test_random;
    bit done;
    logic [15:0] rv;
    logic [15:0] iv;
    done = 0;
    fork
      begin
        for (int n = 0; n < 24; n++) begin
          for (int k = 0; k < 4; k++) begin
            rv = rnd_sample();
            iv = rnd_sample();
            drive_sym(rv, iv);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          end
        end
        in_valid = 1'b0;
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    idle(6);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < obs_q.size(); k++) begin
        n_checks++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL random_word%0d: got %h, required %h", k, obs_q[k], exp_q[k]);
        end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_confidence();
    test_pad();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
